// File: rtl/tap_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tap_controller_pkg
// Brief    : IEEE 1149.1 TAP state encodings, instruction encodings and the
//            state-to-output decode shared by the TAP controller.
// Revision : 1.0  initial release
// ============================================================================
package tap_controller_pkg;

  // Instruction register encodings used by the instruction decoder.
  localparam int unsigned   IR_W       = 4;
  localparam logic [IR_W-1:0] IR_EXTEST  = 4'h0;
  localparam logic [IR_W-1:0] IR_IDCODE  = 4'h1;
  localparam logic [IR_W-1:0] IR_BYPASS  = 4'hF;

  // Standard 1149.1 TAP state encoding; all 16 codes are used.
  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_t;

  // Registered controller outputs, decoded from the state being entered.
  typedef struct packed {
    logic tl_reset;
    logic ir_select;
    logic tdo_en;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
  } tap_out_t;

  function automatic tap_out_t tap_decode(input tap_state_t s);
    tap_out_t o;
    o            = '0;
    o.tl_reset   = (s != TLR);
    o.ir_select  = (s == SEL_IR) || (s == CAP_IR) || (s == SH_IR) ||
                   (s == EX1_IR) || (s == PAUSE_IR) || (s == EX2_IR) ||
                   (s == UPD_IR);
    o.tdo_en     = (s == SH_IR) || (s == SH_DR);
    o.capture_ir = (s == CAP_IR);
    o.shift_ir   = (s == SH_IR);
    o.update_ir  = (s == UPD_IR);
    o.capture_dr = (s == CAP_DR);
    o.shift_dr   = (s == SH_DR);
    o.update_dr  = (s == UPD_DR);
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tap_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : tap_controller_if
// Brief    : TMS input and TAP phase/strobe outputs of the TAP controller.
//            master = test-access driver, slave = TAP controller.
// Revision : 1.0  initial release
// ============================================================================
interface tap_controller_if #(
  parameter int STATE_W = 4
) ();

  logic               tms;
  logic               tl_reset;
  logic               captureIR;
  logic               shiftIR;
  logic               updateIR;
  logic               captureDR;
  logic               shiftDR;
  logic               updateDR;
  logic               ir_select;
  logic               tdo_en;
  logic [STATE_W-1:0] state;

  modport master (
    output tms,
    input  tl_reset, captureIR, shiftIR, updateIR,
           captureDR, shiftDR, updateDR, ir_select, tdo_en, state
  );

  modport slave (
    input  tms,
    output tl_reset, captureIR, shiftIR, updateIR,
           captureDR, shiftDR, updateDR, ir_select, tdo_en, state
  );

endinterface
`default_nettype wire

// File: rtl/tap_controller.sv
`default_nettype none
// ============================================================================
// Module   : tap_controller
// Brief    : IEEE 1149.1 16-state TAP controller. Every output is a flop
//            loaded from the decode of the next state, so outputs line up
//            exactly with the state register and cannot glitch.
// Revision : 1.0  initial release
// ============================================================================
module tap_controller
  import tap_controller_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  wire logic        tck,
  input  wire logic        trst,
  tap_controller_if.slave  tap
);

  tap_state_t state_q;
  tap_state_t state_d;
  tap_out_t   out_q;

  // Next-state transition table driven by TMS.
  always_comb begin
    state_d = TLR;
    case (state_q)
      TLR:      state_d = tap.tms ? TLR      : RTI;
      RTI:      state_d = tap.tms ? SEL_DR   : RTI;
      SEL_DR:   state_d = tap.tms ? SEL_IR   : CAP_DR;
      SEL_IR:   state_d = tap.tms ? TLR      : CAP_IR;
      CAP_DR:   state_d = tap.tms ? EX1_DR   : SH_DR;
      SH_DR:    state_d = tap.tms ? EX1_DR   : SH_DR;
      EX1_DR:   state_d = tap.tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = tap.tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_d = tap.tms ? UPD_DR   : SH_DR;
      UPD_DR:   state_d = tap.tms ? SEL_DR   : RTI;
      CAP_IR:   state_d = tap.tms ? EX1_IR   : SH_IR;
      SH_IR:    state_d = tap.tms ? EX1_IR   : SH_IR;
      EX1_IR:   state_d = tap.tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = tap.tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_d = tap.tms ? UPD_IR   : SH_IR;
      UPD_IR:   state_d = tap.tms ? SEL_DR   : RTI;
      // Any corrupted code falls back to Test-Logic-Reset.
      default:  state_d = TLR;
    endcase
  end

  // State register plus output flops loaded from the next-state decode.
  always_ff @(posedge tck) begin
    if (!trst) begin
      state_q <= TLR;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= tap_decode(state_d);
    end
  end

  assign tap.state     = STATE_W'(state_q);
  assign tap.tl_reset  = out_q.tl_reset;
  assign tap.ir_select = out_q.ir_select;
  assign tap.tdo_en    = out_q.tdo_en;
  assign tap.captureIR = out_q.capture_ir;
  assign tap.shiftIR   = out_q.shift_ir;
  assign tap.updateIR  = out_q.update_ir;
  assign tap.captureDR = out_q.capture_dr;
  assign tap.shiftDR   = out_q.shift_dr;
  assign tap.updateDR  = out_q.update_dr;

endmodule
`default_nettype wire

// File: tb/tb_tap_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_tap_controller
// Brief    : Self-checking bench for tap_controller: vector table of scan
//            sequences, TMS-reset from every state, mid-shift trst, and a
//            long random TMS run against a reference transition table.
// Revision : 1.0  initial release
// ============================================================================
module tb_tap_controller;

  logic tck;
  logic trst;

  tap_controller_if #(.STATE_W(4)) tif ();

  tap_controller #(.STATE_W(4)) dut (
    .tck  (tck),
    .trst (trst),
    .tap  (tif)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  int errors = 0;
  int checks = 0;

  // Reference transition table, indexed by state code.
  logic [3:0] nxt0 [0:15];
  logic [3:0] nxt1 [0:15];
  logic [3:0] model_state;

  // Scoreboard entries: {state, 9 output bits}.
  logic [12:0] sb_q [$];

  typedef struct packed {
    logic       trst;
    logic       tms;
    logic [3:0] st;
  } vec_t;

  vec_t vecs [0:22];

  // Output order: tl_reset, ir_select, tdo_en, capIR, shIR, updIR, capDR, shDR, updDR
  function automatic logic [8:0] exp_outs(input logic [3:0] s);
    logic [8:0] o;
    o[8] = (s != 4'hF);
    o[7] = (s == 4'h4) || (s == 4'hE) || (s == 4'hA) || (s == 4'h9) ||
           (s == 4'hB) || (s == 4'h8) || (s == 4'hD);
    o[6] = (s == 4'hA) || (s == 4'h2);
    o[5] = (s == 4'hE);
    o[4] = (s == 4'hA);
    o[3] = (s == 4'hD);
    o[2] = (s == 4'h6);
    o[1] = (s == 4'h2);
    o[0] = (s == 4'h5);
    return o;
  endfunction

  function automatic logic [8:0] dut_outs();
    return {tif.tl_reset, tif.ir_select, tif.tdo_en, tif.captureIR, tif.shiftIR,
            tif.updateIR, tif.captureDR, tif.shiftDR, tif.updateDR};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One tck edge: drive inputs, push model expectation, compare after the edge.
  task automatic step(input logic trst_v, input logic tms_v);
    logic [12:0] exp_v;
    logic [12:0] act_v;
    int          n_strobe;
    trst     = trst_v;
    tif.tms  = tms_v;
    if (!trst_v) model_state = 4'hF;
    else         model_state = tms_v ? nxt1[model_state] : nxt0[model_state];
    sb_q.push_back({model_state, exp_outs(model_state)});
    @(posedge tck);
    #1;
    act_v = {tif.state, dut_outs()};
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp_v = sb_q.pop_front();
      check("scoreboard", {19'd0, act_v}, {19'd0, exp_v});
    end
    n_strobe = int'(tif.captureIR) + int'(tif.shiftIR) + int'(tif.updateIR) +
               int'(tif.captureDR) + int'(tif.shiftDR) + int'(tif.updateDR);
    checks++;
    if (n_strobe > 1) begin
      errors++;
      $display("FAIL strobe_onehot: got %0d strobes high expected at most 1 at %0t",
               n_strobe, $time);
    end
  endtask

  task automatic setv(input int i, input logic r, input logic m, input logic [3:0] s);
    vecs[i] = '{trst: r, tms: m, st: s};
  endtask

  // Watchdog: the bench must never hang.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr, ir_any, tdo_bad;
    int k;
    logic [3:0] target;

    nxt0 = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
             4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    nxt1 = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
             4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
    model_state = 4'hF;
    trst        = 1'b0;
    tif.tms     = 1'b0;

    // Reset then release to RTI
    setv(0, 1'b0, 1'b0, 4'hF);
    setv(1, 1'b1, 1'b0, 4'hC);
    // IR scan
    setv(2, 1'b1, 1'b1, 4'h7);  setv(3, 1'b1, 1'b1, 4'h4);
    setv(4, 1'b1, 1'b0, 4'hE);  setv(5, 1'b1, 1'b0, 4'hA);
    setv(6, 1'b1, 1'b0, 4'hA);  setv(7, 1'b1, 1'b0, 4'hA);
    setv(8, 1'b1, 1'b0, 4'hA);  setv(9, 1'b1, 1'b1, 4'h9);
    setv(10, 1'b1, 1'b1, 4'hD); setv(11, 1'b1, 1'b0, 4'hC);
    // DR scan with pause
    setv(12, 1'b1, 1'b1, 4'h7); setv(13, 1'b1, 1'b0, 4'h6);
    setv(14, 1'b1, 1'b0, 4'h2); setv(15, 1'b1, 1'b1, 4'h1);
    setv(16, 1'b1, 1'b0, 4'h3); setv(17, 1'b1, 1'b0, 4'h3);
    setv(18, 1'b1, 1'b1, 4'h0); setv(19, 1'b1, 1'b0, 4'h2);
    setv(20, 1'b1, 1'b0, 4'h2); setv(21, 1'b1, 1'b1, 4'h1);
    setv(22, 1'b1, 1'b1, 4'h5);

    cap_ir = 0; sh_ir = 0; upd_ir = 0; cap_dr = 0; sh_dr = 0; upd_dr = 0;
    ir_any = 0; tdo_bad = 0;

    for (int i = 0; i < 23; i++) begin
      step(vecs[i].trst, vecs[i].tms);
      check($sformatf("vec_state[%0d]", i), {28'd0, tif.state}, {28'd0, vecs[i].st});
      if (i == 0) begin
        check("reset_outs", {23'd0, dut_outs()}, 32'd0);
      end else if (i == 1) begin
        check("release_tl_reset", {31'd0, tif.tl_reset}, 32'd1);
      end else if (i <= 11) begin
        cap_ir += int'(tif.captureIR);
        sh_ir  += int'(tif.shiftIR);
        upd_ir += int'(tif.updateIR);
        if (tif.tdo_en !== tif.shiftIR) tdo_bad++;
        if (i == 10) check("ir_updateIR_at_D", {31'd0, tif.updateIR}, 32'd1);
        if (i >= 3 && i <= 10) check("ir_select_ir_col", {31'd0, tif.ir_select}, 32'd1);
      end else begin
        cap_dr += int'(tif.captureDR);
        sh_dr  += int'(tif.shiftDR);
        upd_dr += int'(tif.updateDR);
        ir_any += int'(tif.captureIR) + int'(tif.shiftIR) + int'(tif.updateIR);
      end
    end
    check("ir_capture_cycles", cap_ir, 32'd1);
    check("ir_shift_cycles",   sh_ir,  32'd4);
    check("ir_update_cycles",  upd_ir, 32'd1);
    check("ir_tdo_en_vs_shift", tdo_bad, 32'd0);
    check("dr_capture_cycles", cap_dr, 32'd1);
    check("dr_shift_cycles",   sh_dr,  32'd3);
    check("dr_update_cycles",  upd_dr, 32'd1);
    check("dr_no_ir_strobes",  ir_any, 32'd0);

    // Five TMS=1 edges reach TLR from every state
    for (int s = 0; s < 16; s++) begin
      target = 4'(s);
      step(1'b0, 1'b0);
      k = 0;
      while (model_state != target && k < 400) begin
        step(1'b1, 1'($urandom_range(0, 1)));
        k++;
      end
      check($sformatf("reach_state_%0h", target), {28'd0, tif.state}, {28'd0, target});
      for (int j = 0; j < 5; j++) step(1'b1, 1'b1);
      check($sformatf("tms_reset_from_%0h", target), {28'd0, tif.state}, 32'hF);
    end

    // trst in the middle of a DR shift aborts without an update
    upd_dr = 0;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("mid_in_shdr", {28'd0, tif.state}, 32'h2);
    check("mid_shiftDR_on", {31'd0, tif.shiftDR}, 32'd1);
    step(1'b0, 1'b1);
    upd_dr += int'(tif.updateDR);
    check("mid_reset_state", {28'd0, tif.state}, 32'hF);
    check("mid_shiftDR_off", {31'd0, tif.shiftDR}, 32'd0);
    check("mid_tdo_en_off", {31'd0, tif.tdo_en}, 32'd0);
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 1'b0);
      upd_dr += int'(tif.updateDR);
    end
    check("mid_release_rti", {28'd0, tif.state}, 32'hC);
    check("mid_no_updateDR", upd_dr, 32'd0);

    // Long random TMS run with occasional trst pulses
    for (int n = 0; n < 10000; n++) begin
      step(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)));
    end
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 Parameter STATE_W, default 4, width of the state output; SHALL be fixed by the IEEE 1149.1 state encoding.
REQ-002 Port tck  input  1  test clock; sole clock; all flops SHALL be on its rising edge.
REQ-003 Port trst  input  1  test reset; synchronous, active-low.
REQ-004 Port tms  input  1  test mode select, sampled on the rising edge of tck.
REQ-005 Port tl_reset  output  1  active-low; low while in TEST_LOGIC_RESET; drives the instruction latch reset.
REQ-006 Port captureIR, shiftIR, updateIR  output  1 each  IR-column phase strobes.
REQ-007 Port captureDR, shiftDR, updateDR  output  1 each  DR-column phase strobes.
REQ-008 Port ir_select  output  1  high selects the IR path for the tdo mux, low selects the DR path.
REQ-009 Port tdo_en  output  1  TDO output-enable.
REQ-010 Port state  output  STATE_W  current TAP state, for debug and verification.

Function
REQ-011 The controller SHALL implement the 16-state IEEE 1149.1 TAP FSM with these encodings:
- TLR=F, RTI=C
- SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PAUSE_DR=3, EX2_DR=0, UPD_DR=5
- SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PAUSE_IR=B, EX2_IR=8, UPD_IR=D
REQ-012 Transitions (tms=0 / tms=1) SHALL be:
- TLR: RTI / TLR
- RTI: RTI / SEL_DR
- SEL_DR: CAP_DR / SEL_IR
- SEL_IR: CAP_IR / TLR
- CAP_x: SH_x / EX1_x
- SH_x: SH_x / EX1_x
- EX1_x: PAUSE_x / UPD_x
- PAUSE_x: PAUSE_x / EX2_x
- EX2_x: SH_x / UPD_x
- UPD_x: RTI / SEL_DR
REQ-013 Five consecutive tck edges with tms=1 SHALL reach TLR from any state.
REQ-014 All outputs SHALL be registered, decoded from next-state, so each output is valid in exactly the cycles where state equals the named state; outputs SHALL be glitch-free.
REQ-015 Each strobe SHALL assert only in its matching state:
- captureIR only in CAP_IR; shiftIR only in SH_IR; updateIR only in UPD_IR
- captureDR only in CAP_DR; shiftDR only in SH_DR; updateDR only in UPD_DR
REQ-016 Each capture or update strobe SHALL last exactly one tck cycle per state visit; shift strobes SHALL stay high for every cycle spent in the shift state.
REQ-017 tdo_en SHALL be high only in SH_IR or SH_DR.
REQ-018 ir_select SHALL be high in SEL_IR through UPD_IR, and low otherwise.
REQ-019 tl_reset SHALL be 0 in TLR and 1 otherwise.
REQ-020 At most one capture, shift or update strobe SHALL be high in any cycle.
REQ-021 An unreachable or illegal state value SHALL transition to TLR on the next edge.

Reset
REQ-022 When trst=0 at a rising tck edge, the next state SHALL be TLR regardless of tms.
REQ-023 Reset values SHALL be:
- state=F, tl_reset=0, ir_select=0, tdo_en=0
- all six strobes=0
REQ-024 trst asserted mid-shift SHALL abort the shift with no update strobe issued.
REQ-025 Release of trst with tms=0 SHALL move to RTI on the following edge.

Structure
REQ-026 The tap_state_t enum and its encodings SHALL live in the shared jtag defines/package beside the instruction encodings.
REQ-027 The design SHALL be a single module; no sub-module is natural.
REQ-028 The next-state logic SHALL be a single combinational block, and the state plus output flops SHALL be one sequential block.

Verification
REQ-029 Reset: trst=0 for 1 edge -> state=F, tl_reset=0, all strobes 0; trst=1, tms=0 -> state=C, tl_reset=1.
REQ-030 IR scan: from RTI apply tms=1,1,0,0,0,0,0,1,1,0 -> states 7,4,E,A,A,A,A,9,D,C; captureIR high 1 cycle; shiftIR high 4 cycles; tdo_en matches shiftIR; updateIR high 1 cycle at D; ir_select high from 4 through D.
REQ-031 DR scan with pause: from RTI apply tms=1,0,0,1,0,0,1,0,0,1,1 -> 7,6,2,1,3,3,0,2,2,1,5; updateDR high once; no IR strobe ever high.
REQ-032 TMS reset: from each of the 16 states apply 5 edges with tms=1 -> state=F.
REQ-033 Mid-operation reset: in SH_DR, drop trst for 1 edge -> state=F; shiftDR and tdo_en low the same cycle; updateDR never asserted.
REQ-034 Random tms for 10k cycles against a reference transition model -> state matches every cycle, and REQ-020 holds throughout.
